// File: rtl/glb_core_pcfg_dma_pkg.sv
// Shared types and constants for the GLB parallel-configuration DMA.
// A config word carries the CGRA config address in its upper half and the data in its lower half.
package glb_core_pcfg_dma_pkg;

   localparam int GLB_ADDR_WIDTH  = 19;
   localparam int BANK_DATA_WIDTH = 64;
   localparam int CFG_NUM_WIDTH   = 16;
   localparam int CGRA_CFG_WIDTH  = 32;
   localparam int BYTE_OFFSET     = 3;

   localparam logic [GLB_ADDR_WIDTH-1:0] WORD_STRIDE     = GLB_ADDR_WIDTH'(1 << BYTE_OFFSET);
   localparam logic [GLB_ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~GLB_ADDR_WIDTH'((1 << BYTE_OFFSET) - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } pcfg_state_e;

   typedef struct packed {
      logic [CGRA_CFG_WIDTH-1:0] addr;
      logic [CGRA_CFG_WIDTH-1:0] data;
   } cfg_word_t;

   function automatic cfg_word_t split_cfg_word(input logic [BANK_DATA_WIDTH-1:0] word);
      return cfg_word_t'(word);
   endfunction

endpackage

// File: rtl/glb_core_pcfg_dma_if.sv
// Read-request / read-response / CGRA-config bus of the PC DMA.
// Valid-only handshake: rdrq_en, rdrs_valid and cgra_cfg_wr each qualify their payload in the same
// cycle; there is no ready, the router always accepts requests and returns responses in order.
interface glb_core_pcfg_dma_if;
   import glb_core_pcfg_dma_pkg::*;

   logic                       rdrq_en;
   logic [GLB_ADDR_WIDTH-1:0]  rdrq_addr;
   logic                       rdrs_valid;
   logic [BANK_DATA_WIDTH-1:0] rdrs_data;
   logic                       cgra_cfg_wr;
   logic [CGRA_CFG_WIDTH-1:0]  cgra_cfg_addr;
   logic [CGRA_CFG_WIDTH-1:0]  cgra_cfg_data;

   modport master (
      output rdrq_en, rdrq_addr, cgra_cfg_wr, cgra_cfg_addr, cgra_cfg_data,
      input  rdrs_valid, rdrs_data
   );

   modport slave (
      input  rdrq_en, rdrq_addr, cgra_cfg_wr, cgra_cfg_addr, cgra_cfg_data,
      output rdrs_valid, rdrs_data
   );

endinterface

// File: rtl/glb_core_pcfg_dma.sv
// Parallel-configuration DMA: streams cfg_num words from GLB to the CGRA config bus.
// Requests go out back-to-back; each in-order response becomes one registered config write.
module glb_core_pcfg_dma
   import glb_core_pcfg_dma_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_pcfg_mode,
   input  logic [GLB_ADDR_WIDTH-1:0] cfg_start_addr,
   input  logic [CFG_NUM_WIDTH-1:0]  cfg_num,
   input  logic                      start_pulse,
   glb_core_pcfg_dma_if.master       bus,
   output logic                      busy,
   output logic                      done_pulse,
   output pcfg_state_e               state_dbg
);

   pcfg_state_e               state_q, state_d;
   logic [GLB_ADDR_WIDTH-1:0] addr_q;
   logic [CFG_NUM_WIDTH-1:0]  num_q;
   logic [CFG_NUM_WIDTH-1:0]  req_cnt_q;
   logic [CFG_NUM_WIDTH-1:0]  rsp_cnt_q;
   logic                      cfg_wr_q;
   cfg_word_t                 cfg_word_q;

   logic start_ok;
   logic rsp_in;
   logic last_req;
   logic last_rsp;

   assign start_ok = start_pulse & cfg_pcfg_mode;
   assign rsp_in   = bus.rdrs_valid & ((state_q == ST_REQ) | (state_q == ST_WAIT));
   // Counters compare against num-1 so that the maximum count never wraps the register.
   assign last_req = (req_cnt_q == (num_q - CFG_NUM_WIDTH'(1)));
   assign last_rsp = rsp_in & (rsp_cnt_q == (num_q - CFG_NUM_WIDTH'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = (cfg_num == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (last_req) begin
               state_d = last_rsp ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (last_rsp) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         num_q     <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else if ((state_q == ST_IDLE) && start_ok) begin
         addr_q    <= cfg_start_addr & ADDR_ALIGN_MASK;
         num_q     <= cfg_num;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else begin
         if (state_q == ST_REQ) begin
            addr_q    <= addr_q + WORD_STRIDE;
            req_cnt_q <= req_cnt_q + CFG_NUM_WIDTH'(1);
         end
         if (rsp_in) begin
            rsp_cnt_q <= rsp_cnt_q + CFG_NUM_WIDTH'(1);
         end
      end
   end

   // Config address/data hold their last value between strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_wr_q   <= 1'b0;
         cfg_word_q <= '0;
      end else begin
         cfg_wr_q <= rsp_in;
         if (rsp_in) begin
            cfg_word_q <= split_cfg_word(bus.rdrs_data);
         end
      end
   end

   assign bus.rdrq_en       = (state_q == ST_REQ);
   assign bus.rdrq_addr     = addr_q;
   assign bus.cgra_cfg_wr   = cfg_wr_q;
   assign bus.cgra_cfg_addr = cfg_word_q.addr;
   assign bus.cgra_cfg_data = cfg_word_q.data;
   assign busy              = (state_q != ST_IDLE);
   assign done_pulse        = (state_q == ST_DONE);
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_glb_core_pcfg_dma.sv
// Bench for the PC DMA: a random-latency in-order responder plays the router, and a scoreboard
// checks request addresses/cycles, config writes and done pulses against expectations.
module tb_glb_core_pcfg_dma;
   import glb_core_pcfg_dma_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      cfg_pcfg_mode;
   logic [GLB_ADDR_WIDTH-1:0] cfg_start_addr;
   logic [CFG_NUM_WIDTH-1:0]  cfg_num;
   logic                      start_pulse;
   logic                      busy;
   logic                      done_pulse;
   pcfg_state_e               state_dbg;

   glb_core_pcfg_dma_if bus();

   glb_core_pcfg_dma dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_pcfg_mode  (cfg_pcfg_mode),
      .cfg_start_addr (cfg_start_addr),
      .cfg_num        (cfg_num),
      .start_pulse    (start_pulse),
      .bus            (bus),
      .busy           (busy),
      .done_pulse     (done_pulse),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [GLB_ADDR_WIDTH-1:0]  exp_req_q[$];
   int                         exp_req_cyc_q[$];
   logic [BANK_DATA_WIDTH-1:0] exp_wr_q[$];
   bit                         exp_done_q[$];
   int                         pend_due_q[$];
   logic [BANK_DATA_WIDTH-1:0] pend_data_q[$];

   int last_due = 0;
   int lat_min  = 1;
   int lat_max  = 1;
   bit drop_rsp = 1'b0;
   int req_seen = 0;
   int wr_seen  = 0;
   int done_seen = 0;
   int tests_run = 0;
   int fails     = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_event(input string name);
      tests_run++;
      fails++;
      $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
   endfunction

   // ---------------- responder (router model) ----------------
   always @(posedge clk) begin
      #1;
      if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
         bus.rdrs_valid = 1'b1;
         bus.rdrs_data  = pend_data_q[0];
         if (!drop_rsp) exp_wr_q.push_back(pend_data_q[0]);
         void'(pend_due_q.pop_front());
         void'(pend_data_q.pop_front());
      end else begin
         bus.rdrs_valid = 1'b0;
         bus.rdrs_data  = '0;
      end
      if (drop_rsp && pend_due_q.size() == 0) drop_rsp = 1'b0;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rdrq_en) begin
            int due;
            req_seen++;
            if (exp_req_q.size() == 0) begin
               fail_event("unexpected_req");
            end else begin
               check("req_addr", 64'(bus.rdrq_addr), 64'(exp_req_q.pop_front()));
               check("req_cycle", 64'(cyc), 64'(exp_req_cyc_q.pop_front()));
            end
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due_q.push_back(due);
            pend_data_q.push_back({$urandom, $urandom});
         end
         if (bus.cgra_cfg_wr) begin
            logic [63:0] w;
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
               fail_event("unexpected_wr");
            end else begin
               w = exp_wr_q.pop_front();
               check("cfg_addr", 64'(bus.cgra_cfg_addr), 64'(w[63:32]));
               check("cfg_data", 64'(bus.cgra_cfg_data), 64'(w[31:0]));
            end
         end
         if (done_pulse) begin
            bit with_wr;
            done_seen++;
            if (exp_done_q.size() == 0) begin
               fail_event("unexpected_done");
            end else begin
               with_wr = exp_done_q.pop_front();
               check("done_with_last_wr", 64'(bus.cgra_cfg_wr), 64'(with_wr));
               check("done_reqs_left", 64'(exp_req_q.size()), 64'd0);
               check("done_wrs_left", 64'(exp_wr_q.size()), 64'd0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_xfer(input logic [GLB_ADDR_WIDTH-1:0] a, input int n,
                             input bit mode, input bit accept);
      logic [GLB_ADDR_WIDTH-1:0] base;
      @(posedge clk);
      #1;
      cfg_start_addr = a;
      cfg_num        = CFG_NUM_WIDTH'(n);
      cfg_pcfg_mode  = mode;
      start_pulse    = 1'b1;
      if (accept) begin
         base = a & 19'h7FFF8;
         for (int k = 0; k < n; k++) begin
            exp_req_q.push_back(base + GLB_ADDR_WIDTH'(8 * k));
            exp_req_cyc_q.push_back(cyc + 1 + k);
         end
         exp_done_q.push_back(n != 0);
      end
      @(posedge clk);
      #1;
      start_pulse = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_seen;
      bit got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_seen > d0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_event("done_timeout");
   endtask

   task automatic run_xfer(input logic [GLB_ADDR_WIDTH-1:0] a, input int n, input int budget);
      int w0 = wr_seen;
      start_xfer(a, n, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done(budget);
      check("wr_count", 64'(wr_seen - w0), 64'(n));
      @(negedge clk);
      #1;
      check("busy_after_done", 64'(busy), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0;
      int w0;
      int d0;
      bit got;
      reset          = 1'b1;
      cfg_pcfg_mode  = 1'b0;
      cfg_start_addr = '0;
      cfg_num        = '0;
      start_pulse    = 1'b0;
      #12;
      check("rst_rdrq_en", 64'(bus.rdrq_en), 64'd0);
      check("rst_rdrq_addr", 64'(bus.rdrq_addr), 64'd0);
      check("rst_cfg_wr", 64'(bus.cgra_cfg_wr), 64'd0);
      check("rst_cfg_addr", 64'(bus.cgra_cfg_addr), 64'd0);
      check("rst_cfg_data", 64'(bus.cgra_cfg_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done_pulse), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // basic transfer, fixed 2-cycle latency
      lat_min = 2;
      lat_max = 2;
      run_xfer(19'h00100, 4, 100);

      // zero-length transfer
      r0 = req_seen;
      w0 = wr_seen;
      start_xfer(19'h00040, 0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check("num0_done", 64'(done_pulse), 64'd1);
      check("num0_busy", 64'(busy), 64'd1);
      check("num0_rdrq", 64'(bus.rdrq_en), 64'd0);
      @(negedge clk);
      #1;
      check("num0_done_gone", 64'(done_pulse), 64'd0);
      check("num0_busy_gone", 64'(busy), 64'd0);
      check("num0_no_req", 64'(req_seen - r0), 64'd0);
      check("num0_no_wr", 64'(wr_seen - w0), 64'd0);

      // address wrap, unaligned low bits ignored
      run_xfer(19'h7FFF8, 3, 100);
      run_xfer(19'h7FFF5, 2, 100);

      // start with mode off
      r0 = req_seen;
      start_xfer(19'h00800, 5, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      #1;
      check("mode0_busy", 64'(busy), 64'd0);
      check("mode0_no_req", 64'(req_seen - r0), 64'd0);

      // second start while busy
      r0 = req_seen;
      start_xfer(19'h00400, 6, 1'b1, 1'b1);
      start_xfer(19'h09990, 5, 1'b1, 1'b0);
      wait_done(200);
      check("restart_req_count", 64'(req_seen - r0), 64'd6);
      repeat (3) @(negedge clk);

      // reset after 2 of 8 requests
      r0 = req_seen;
      start_xfer(19'h02000, 8, 1'b1, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (req_seen >= r0 + 2) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!got) fail_event("reset_test_timeout");
      #1;
      reset = 1'b1;
      drop_rsp = 1'b1;
      #1;
      check("mid_rst_rdrq_en", 64'(bus.rdrq_en), 64'd0);
      check("mid_rst_rdrq_addr", 64'(bus.rdrq_addr), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done_pulse), 64'd0);
      check("mid_rst_cfg_wr", 64'(bus.cgra_cfg_wr), 64'd0);
      exp_req_q.delete();
      exp_req_cyc_q.delete();
      exp_wr_q.delete();
      exp_done_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      w0 = wr_seen;
      d0 = done_seen;
      repeat (30) @(negedge clk);
      #1;
      check("post_rst_no_wr", 64'(wr_seen - w0), 64'd0);
      check("post_rst_no_done", 64'(done_seen - d0), 64'd0);
      check("post_rst_req_total", 64'(req_seen - r0), 64'd2);

      // random latency 1..20
      lat_min = 1;
      lat_max = 20;
      run_xfer(19'($urandom), 64, 3000);
      for (int t = 0; t < 4; t++) begin
         run_xfer(19'($urandom), int'($urandom_range(40, 1)), 2000);
      end
      lat_min = 1;
      lat_max = 1;
      run_xfer(19'($urandom), 64, 500);
      lat_min = 1;
      lat_max = 3;
      run_xfer(19'($urandom), 300, 2000);

      repeat (30) @(negedge clk);
      #1;
      check("end_req_q_empty", 64'(exp_req_q.size()), 64'd0);
      check("end_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
      check("end_done_q_empty", 64'(exp_done_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

endmodule
